// File: rtl/alu_issue_arb.sv
// Two-slot issue arbiter for the shared registered ALU, with in-flight tracking and a tagged result FIFO.
// Define ALU_ARB_FIXED_PRIO_EN for strict req0 priority; otherwise ties are resolved round-robin.
module alu_issue_arb #(
    parameter int TAG_W     = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [4:0]       req0_aluop,
    input  logic [31:0]      req0_src1,
    input  logic [31:0]      req0_src2,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [4:0]       req1_aluop,
    input  logic [31:0]      req1_src1,
    input  logic [31:0]      req1_src2,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [4:0]       alu_op,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    input  logic [31:0]      alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_src,
    output logic             res_err,
    output logic             busy
);
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int ENT_W = 32 + TAG_W + 2;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
            5'd16, 5'd17, 5'd18, 5'd22, 5'd24, 5'd26, 5'd28, 5'd30: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        ptr_next = (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENT_W-1:0] mem [RES_DEPTH];
    logic [ENT_W-1:0] head;
    logic             vld_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             src_p1;
    logic             err_p1;
    logic             pop;
    logic             issue_ok;
    logic             grant0;
    logic             grant1;
    logic [OCC_W-1:0] occupancy;

    // Slots already spoken for once this cycle's pop and in-flight push settle.
    assign res_valid = (count != '0);
    assign pop       = res_valid & res_ready;
    assign occupancy = OCC_W'(count) + OCC_W'(vld_p1) - OCC_W'(pop);
    assign issue_ok  = (occupancy < OCC_W'(RES_DEPTH));

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = issue_ok & req0_valid;
        grant1 = issue_ok & req1_valid & ~req0_valid;
    end
`else
    logic last_grant;

    always_comb begin
        grant0 = issue_ok & req0_valid & (~req1_valid | last_grant);
        grant1 = issue_ok & req1_valid & (~req0_valid | ~last_grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0 | grant1) begin
            last_grant <= grant1;
        end
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_op  = '0;
        alu_in1 = '0;
        alu_in2 = '0;
        if (grant0) begin
            alu_op  = req0_aluop;
            alu_in1 = req0_src1;
            alu_in2 = req0_src2;
        end else if (grant1) begin
            alu_op  = req1_aluop;
            alu_in1 = req1_src1;
            alu_in2 = req1_src2;
        end
    end

    // Stage p1: op sits in the ALU output register; its side info waits here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= grant0 | grant1;
        end
    end

    always_ff @(posedge clk) begin
        if (grant0 | grant1) begin
            tag_p1 <= grant1 ? req1_tag : req0_tag;
            src_p1 <= grant1;
            err_p1 <= ~op_legal(alu_op);
        end
    end

    // Stage p2: result FIFO; entry payload is not reset, only pointers and count.
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            mem[wr_ptr] <= {(err_p1 ? 32'd0 : alu_out), tag_p1, src_p1, err_p1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (vld_p1) wr_ptr <= ptr_next(wr_ptr);
            if (pop)    rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(vld_p1) - CNT_W'(pop);
        end
    end

    assign head     = res_valid ? mem[rd_ptr] : '0;
    assign res_data = head[ENT_W-1 -: 32];
    assign res_tag  = head[TAG_W+1:2];
    assign res_src  = head[1];
    assign res_err  = head[0];
    assign busy     = vld_p1 | res_valid;

endmodule

// File: tb/tb_alu_issue_arb.sv
// Scoreboard bench for alu_issue_arb: directed vectors with hand-computed results, a stand-in
// registered ALU, a driver that records acceptances and a monitor that checks each popped result.
module tb_alu_issue_arb;
    localparam int TAG_W     = 4;
    localparam int RES_DEPTH = 2;

    typedef struct packed {
        logic [4:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp_data;
        logic             exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             src;
        logic             err;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]       req0_aluop, req1_aluop;
    logic [31:0]      req0_src1, req0_src2, req1_src1, req1_src2;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [4:0]       alu_op;
    logic [31:0]      alu_in1, alu_in2, alu_out;
    logic             res_valid, res_ready, res_src, res_err, busy;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;

    vec_t q0[$];
    vec_t q1[$];
    res_t sb[$];
    int   glog[$];
    int   gcyc[$];
    int   acc_cnt = 0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_arb #(.TAG_W(TAG_W), .RES_DEPTH(RES_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
        .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
        .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_tag(req1_tag),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_src(res_src), .res_err(res_err), .busy(busy)
    );

    // Stand-in for the shared ALU: registered, cleared by the same reset.
    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb_v;
        sa   = a;
        sb_v = b;
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd5:    return a ^ b;
            5'd24:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb_v);
            5'd28:   return (b == 0) ? a : 32'(sa % sb_v);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_out <= '0;
        else        alu_out <= alu_model(alu_op, alu_in1, alu_in2);
    end

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                                input logic exp_err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.tag = tag; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_acc(input int target, input string name);
        int k = 0;
        while (acc_cnt < target && k < 100) begin
            @(posedge clk); #2;
            k++;
        end
        if (acc_cnt < target) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: accepted %0d, required %0d", name, acc_cnt, target);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || busy) && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        if (k >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: busy=%0b pending=%0d, required idle", name, busy, sb.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); sb.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Driver: presents queue heads after each posedge, records acceptances at the negedge.
    initial begin : driver
        req0_valid = 0; req0_aluop = 0; req0_src1 = 0; req0_src2 = 0; req0_tag = 0;
        req1_valid = 0; req1_aluop = 0; req1_src1 = 0; req1_src2 = 0; req1_tag = 0;
        forever begin
            @(posedge clk); #1;
            req0_valid = rst_n && (q0.size() != 0);
            req0_aluop = req0_valid ? q0[0].op  : '0;
            req0_src1  = req0_valid ? q0[0].a   : '0;
            req0_src2  = req0_valid ? q0[0].b   : '0;
            req0_tag   = req0_valid ? q0[0].tag : '0;
            req1_valid = rst_n && (q1.size() != 0);
            req1_aluop = req1_valid ? q1[0].op  : '0;
            req1_src1  = req1_valid ? q1[0].a   : '0;
            req1_src2  = req1_valid ? q1[0].b   : '0;
            req1_tag   = req1_valid ? q1[0].tag : '0;
            @(negedge clk);
            if (rst_n && req0_valid && req0_ready && q0.size() != 0) begin
                sb.push_back(res_t'{q0[0].exp_data, q0[0].tag, 1'b0, q0[0].exp_err});
                void'(q0.pop_front());
                glog.push_back(0); gcyc.push_back(cyc); acc_cnt++;
            end
            if (rst_n && req1_valid && req1_ready && q1.size() != 0) begin
                sb.push_back(res_t'{q1[0].exp_data, q1[0].tag, 1'b1, q1[0].exp_err});
                void'(q1.pop_front());
                glog.push_back(1); gcyc.push_back(cyc); acc_cnt++;
            end
        end
    end

    initial begin : monitor
        res_t got;
        res_t exp_r;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && res_ready) begin
                got = res_t'{res_data, res_tag, res_src, res_err};
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_unexpected: got data=%h tag=%0d src=%0d err=%0d, required no result",
                             got.data, got.tag, got.src, got.err);
                end else begin
                    exp_r = sb.pop_front();
                    if (got !== exp_r) begin
                        n_fail++;
                        $display("FAIL result: got data=%h tag=%0d src=%0d err=%0d, required data=%h tag=%0d src=%0d err=%0d",
                                 got.data, got.tag, got.src, got.err,
                                 exp_r.data, exp_r.tag, exp_r.src, exp_r.err);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        int k;
`ifdef ALU_ARB_FIXED_PRIO_EN
        int exp_g[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        int exp_g[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        rst_n = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        // Reset state
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_tag", 32'(res_tag), 0);
        chk("rst_res_src", 32'(res_src), 0);
        chk("rst_res_err", 32'(res_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req0_ready", 32'(req0_ready), 0);
        chk("rst_req1_ready", 32'(req1_ready), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_alu_in1", alu_in1, 0);
        chk("rst_alu_in2", alu_in2, 0);

        // Single add 5+7, two-cycle latency to res_valid
        base = acc_cnt;
        q0.push_back(mk(5'd0, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0));
        wait_acc(base + 1, "single");
        k = 1;
        while (!res_valid && k < 10) begin
            @(posedge clk); #2;
            k++;
        end
        chk("single_latency", 32'(k), 2);
        wait_idle("single");

        // Tie: both valid continuously, grant order and sustained throughput
        do_reset();
        base = glog.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(5'd1, 32'd10, 32'd3, 4'(2 * i + 1), 32'd7, 1'b0));
            q1.push_back(mk(5'd5, 32'hF0, 32'h0F, 4'(2 * i + 2), 32'hFF, 1'b0));
        end
        wait_acc(acc_cnt + 8, "tie");
        wait_idle("tie");
        if (glog.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("tie_grant_%0d", i), 32'(glog[base + i]), 32'(exp_g[i]));
            end
            chk("tie_span", 32'(gcyc[base + 7] - gcyc[base]), 7);
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL tie_grants: got %0d grants, required 8", glog.size() - base);
        end

        // Backpressure: only RES_DEPTH ops outstanding while res_ready is low
        res_ready = 1'b0;
        base = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            q0.push_back(mk(5'd0, 32'(i), 32'd100, 4'(9 + i), 32'(100 + i), 1'b0));
        end
        repeat (6) begin
            @(posedge clk); #2;
        end
        chk("bp_accepted", 32'(acc_cnt - base), 2);
        chk("bp_req0_ready", 32'(req0_ready), 0);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_res_valid", 32'(res_valid), 1);
        res_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(req0_ready), 1);
        wait_idle("bp");
        chk("bp_all_accepted", 32'(acc_cnt - base), 5);

        // Illegal opcode, then signed div/rem
        q1.push_back(mk(5'd11, 32'd1, 32'd1, 4'd5, 32'd0, 1'b1));
        q1.push_back(mk(5'd24, 32'hFFFF_FFF9, 32'd2, 4'd6, 32'hFFFF_FFFD, 1'b0));
        q1.push_back(mk(5'd28, 32'hFFFF_FFF9, 32'd2, 4'd7, 32'hFFFF_FFFF, 1'b0));
        wait_idle("illegal");

        // Reset with results queued and one op in flight
        res_ready = 1'b0;
        base = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(5'd0, 32'(i), 32'd1, 4'(i + 1), 32'(i + 1), 1'b0));
        end
        wait_acc(base + 2, "midrst");
        chk("midrst_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        q0.delete(); q1.delete(); sb.delete();
        #1;
        chk("midrst_res_valid", 32'(res_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #2;
        chk("midrst_res_valid_next", 32'(res_valid), 0);
        repeat (8) begin
            @(posedge clk); #2;
        end
        chk("midrst_no_stale", 32'(res_valid), 0);
        chk("midrst_idle", 32'(busy), 0);

        // Recovery after reset
        q1.push_back(mk(5'd0, 32'd1, 32'd2, 4'd14, 32'd3, 1'b0));
        wait_idle("recover");
        chk("final_pending", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_arb.md
# alu_issue_arb

Issue arbiter and result sequencer for the shared registered integer/M-extension ALU. Two requesters (issue slots 0 and 1) present operations with valid/ready handshakes. The block grants at most one per cycle and drives the ALU operand/opcode inputs. It tracks the single in-flight operation through the ALU's one-cycle registered output and returns tagged results through a small result FIFO with backpressure.

## Interface

Parameters:
- TAG_W, 4, width of requester-supplied tag carried with each op
- RES_DEPTH, 2, result FIFO depth in entries (≥2)

Ports:
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  reset, asynchronous assert, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_aluop / req1_aluop  in  5  ALU opcode
- req0_src1 / req1_src1  in  32  operand 1 (pc for auipc)
- req0_src2 / req1_src2  in  32  operand 2 (imm/shamt)
- req0_tag / req1_tag  in  TAG_W  tag returned with result
- alu_op  out  5  to ALU aluop
- alu_in1, alu_in2  out  32  to ALU aluin1/aluin2
- alu_out  in  32  ALU registered result
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_data  out  32  result
- res_tag  out  TAG_W  tag of result
- res_src  out  1  originating requester (0/1)
- res_err  out  1  opcode was illegal
- busy  out  1  in-flight op or FIFO non-empty

## Operation

- Legal opcodes: 0–9, 16, 17, 18, 22, 24, 26, 28, 30. Any other value is accepted normally but flagged err. Its FIFO entry gets res_data=0, res_err=1, and alu_out is ignored.
- pop = res_valid & res_ready. issue_ok = (fifo_count + inflight_v − pop) < RES_DEPTH. This is a combinational path from res_ready to reqX_ready.
- Grant, only when issue_ok:
  - Only one valid: grant it.
  - Both valid: grant the requester not in last_grant (round-robin).
  - No valid: no grant.
- reqX_ready = issue_ok & grantX. The non-granted requester sees ready=0 and must hold its request stable.
- ALU drive:
  - Grant: alu_op/alu_in1/alu_in2 are combinational copies of the granted request.
  - No grant: alu_op=0, alu_in1=0, alu_in2=0. The ALU still updates, and that result is discarded.
- In-flight register (inflight_v, tag, src, err):
  - On grant: loaded at the posedge ending the grant cycle; last_grant updated to the granted index.
  - No grant: inflight_v cleared.
- Push: when inflight_v=1, {alu_out or 0, tag, src, err} is written to the FIFO at the posedge ending that cycle.
- FIFO: circular, RES_DEPTH entries, wr/rd pointers wrap modulo RES_DEPTH. Push and pop may occur in the same cycle at any count, including full. Results leave in issue order.
- busy = inflight_v | (fifo_count != 0).

## Timing

- Reset: all outputs 0 (res_valid, res_data, res_tag, res_src, res_err, busy, reqX_ready gated by idle reset state, alu_* = 0). inflight_v=0, fifo_count=0, pointers=0, last_grant=1 (req0 wins first tie).
- Latency: request accepted in cycle N → alu_out valid in N+1 → res_valid=1 in N+2 when the FIFO is empty and not stalled.
- Throughput: one op per cycle sustained while res_ready=1.
- res_ready held low: after RES_DEPTH ops outstanding (FIFO plus in-flight), both reqX_ready=0. Resumes in the same cycle res_ready rises.
- Reset asserted mid-operation: in-flight op and all FIFO contents are dropped immediately. The ALU shares rst_n and clears too. No result is produced for ops accepted before reset.
- Request fields must be held stable while valid&!ready.

## Configuration

- ALU_ARB_FIXED_PRIO_EN defined: req0 strictly wins over req1 whenever both are valid. last_grant is not used.
- Not defined: round-robin as above.

## Test plan

- Reset: after rst_n rises, all outputs are 0. A single req0 {aluop=0, 5, 7, tag=3} gives res_valid two cycles later with res_data=12, tag=3, src=0, err=0.
- Tie: both requesters valid continuously, req0 sub 10−3 and req1 xor 0xF0^0x0F, res_ready=1. Grants alternate 0,1,0,1. Results 7 and 0xFF arrive in grant order, one per cycle.
- Backpressure (RES_DEPTH=2): res_ready=0 with 5 back-to-back req0 ops. Exactly 2 are accepted, then req0_ready=0 and busy=1. Raising res_ready drains results in order and the remaining ops are accepted.
- Illegal opcode: req1 aluop=11 with operands 1,1 → res_err=1, res_data=0, src=1. A following div(−7,2) gives −3 and rem(−7,2) gives −1.
- Reset while two results are queued and one op is in-flight → res_valid=0 the next cycle. No stale result appears afterwards.
- ALU_ARB_FIXED_PRIO_EN defined, both requesters valid for 4 cycles → four req0 grants, zero req1 grants.
